// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC unit: holds the fetch PC, issues word fetches,
// honours the single delay slot and hands {pc, instr} to IF/ID.
// Ports: clk/rst_n; br_valid/br_pc/br_target redirect from ID;
// imem_req/imem_addr/imem_ack/imem_rdata fetch port;
// if_valid/if_ready/if_pc/if_instr delivery handshake to IF/ID.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [1:0]  state;
    logic [31:0] pc_q;
    logic        pend_v;
    logic [31:0] pend_tgt;
    logic [31:0] pend_slot;

    logic [31:0] br_slot;
    logic [31:0] br_tgt;
    logic        in_issue;
    logic        in_hold;
    logic        ack_fire;
    logic        live_iss;
    logic        pend_iss;
    logic        live_hold;
    logic        pend_hold;
    logic        apply_live;
    logic        apply_pend;
    logic [31:0] next_iss;
    logic [31:0] next_hold;

    assign br_slot  = br_pc + 32'd4;
    assign br_tgt   = {br_target[31:2], 2'b00};
    assign in_issue = (state == ISSUE);
    assign in_hold  = (state == HOLD);
    assign ack_fire = in_issue && imem_ack;

    // Slot being fetched right now (ISSUE) or already held (HOLD).
    assign live_iss  = ack_fire && br_valid && (pc_q == br_slot);
    assign pend_iss  = ack_fire && pend_v && (pc_q == pend_slot);
    assign live_hold = in_hold && br_valid && (if_pc == br_slot);
    assign pend_hold = in_hold && pend_v && (if_pc == pend_slot);

    assign apply_live = live_iss || live_hold;
    assign apply_pend = pend_iss || pend_hold;

    assign next_iss  = live_iss ? br_tgt :
                       pend_iss ? pend_tgt :
                       pc_q + 32'd4;
    assign next_hold = live_hold ? br_tgt :
                       pend_hold ? pend_tgt :
                       pc_q;

    // Request is a pure function of state so reset drops it at once.
    assign imem_req  = in_issue;
    assign imem_addr = in_issue ? pc_q : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc_q     <= RESET_PC;
            if_valid <= 1'b0;
            if_pc    <= 32'd0;
            if_instr <= 32'd0;
        end else begin
            case (state)
                BOOT: state <= ISSUE;
                ISSUE: begin
                    if (imem_ack) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc_q;
                        if_valid <= 1'b1;
                        pc_q     <= next_iss;
                        state    <= HOLD;
                    end
                end
                HOLD: begin
                    pc_q <= next_hold;
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // A live redirect consumed on this edge is never parked; any other
    // new branch replaces whatever entry is waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v    <= 1'b0;
            pend_tgt  <= 32'd0;
            pend_slot <= 32'd0;
        end else if (apply_live) begin
            pend_v <= 1'b0;
        end else if (br_valid) begin
            pend_v    <= 1'b1;
            pend_tgt  <= br_tgt;
            pend_slot <= br_slot;
        end else if (apply_pend) begin
            pend_v <= 1'b0;
        end
    end

endmodule
